// File: rtl/ns_quantizer.sv
// ns_quantizer: multi-channel requantizer from IN_W to OUT_W bits, with an
// optional first-order error-feedback (noise-shaping) path per channel.
//
// Pipeline: input register (stage 1) -> v register (stage 2) -> output register.
// A sample accepted at edge n appears on the outputs after edge n+2.
// Stage 1 forms v = x + E[ch]. Stage 2 rounds, clamps and forms the residual error.
// The residual is written back to E[ch] as the sample moves on to the output register.
// When the previous sample of the same channel is still in stage 2,
// its error is forwarded straight into stage 1.
//
// Optional feature: define NS_QUANTIZER_SAT_CNT_EN to add sat_cnt_o. This is a
// 16-bit saturating count of output transfers that carried sat_o = 1.

module ns_quantizer #(
    parameter int  IN_W  = 16,
    parameter int  OUT_W = 4,
    parameter int  N_CH  = 2,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [CH_W-1:0]         in_ch_i,
    input  logic signed [IN_W-1:0]  x_in_i,
    input  logic                    mode_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [CH_W-1:0]         out_ch_o,
    output logic signed [OUT_W-1:0] q_out_o,
    output logic signed [IN_W-1:0]  err_o,
    output logic                    sat_o
`ifdef NS_QUANTIZER_SAT_CNT_EN
    ,
    output logic [15:0]             sat_cnt_o
`endif
);

    localparam int SHIFT = IN_W - OUT_W;
    localparam int W2    = IN_W + 2;

    // Rounding offset and clamp limits, all in the W2-bit internal format.
    localparam logic signed [W2-1:0] HALF = W2'(1) << (SHIFT - 1);
    localparam logic signed [W2-1:0] QMAX = {{(W2-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [W2-1:0] QMIN = {{(W2-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [W2-1:0] EMAX = {3'b000, {(IN_W-1){1'b1}}};
    localparam logic signed [W2-1:0] EMIN = {3'b111, {(IN_W-1){1'b0}}};

    // Reset-release flag so in_ready_o stays low while reset is asserted
    logic                   rst_done;

    // Stage 1: raw accepted sample
    logic                   s1_valid;
    logic                   s1_mode;
    logic                   s1_ch_ok;
    logic [CH_W-1:0]        s1_ch;
    logic signed [IN_W-1:0] s1_x;

    // Stage 2: feedback-corrected value
    logic                   s2_valid;
    logic                   s2_ch_ok;
    logic [CH_W-1:0]        s2_ch;
    logic signed [W2-1:0]   s2_v;

    // Per-channel error memory
    logic signed [IN_W-1:0] e_mem [N_CH];

    // Combinational datapath
    logic signed [IN_W-1:0] fb;
    logic signed [W2-1:0]   v;
    logic signed [W2-1:0]   r;
    logic signed [W2-1:0]   q_cl;
    logic                   q_sat;
    logic signed [W2-1:0]   e_full;
    logic signed [IN_W-1:0] e_sat;

    // Handshake chain, evaluated from the output backwards
    logic out_free;
    logic s2_adv;
    logic s2_free;
    logic s1_adv;
    logic accept;
    logic in_ch_ok;

    assign out_free   = !out_valid_o || out_ready_i;
    assign s2_adv     = s2_valid && out_free;
    assign s2_free    = !s2_valid || s2_adv;
    assign s1_adv     = s1_valid && s2_free;
    assign in_ready_o = rst_done && (!s1_valid || s1_adv);
    assign accept     = in_valid_i && in_ready_o;
    assign in_ch_ok   = (int'(in_ch_i) < N_CH);

    // Stage 1: select the feedback term (forwarded from stage 2 or stored) and form v
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        fb = '0;
        if (s1_mode && s1_ch_ok) begin
            if (s2_valid && s2_ch_ok && (s2_ch == s1_ch)) begin
                fb = e_sat;
            end else begin
                fb = e_mem[s1_ch];
            end
        end
        v = W2'(s1_x) + W2'(fb);
    end

    // Stage 2: round half toward +inf, clamp to OUT_W, derive the clamped residual
    always_comb begin
        r     = (s2_v + HALF) >>> SHIFT;
        q_cl  = r;
        q_sat = 1'b0;
        if (r > QMAX) begin
            q_cl  = QMAX;
            q_sat = 1'b1;
        end else if (r < QMIN) begin
            q_cl  = QMIN;
            q_sat = 1'b1;
        end
        e_full = s2_v - (q_cl <<< SHIFT);
        e_sat  = e_full[IN_W-1:0];
        if (e_full > EMAX) begin
            e_sat = EMAX[IN_W-1:0];
        end else if (e_full < EMIN) begin
            e_sat = EMIN[IN_W-1:0];
        end
    end

    // Reset-release flag: set on the first clock edge after rst_ni rises
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_ni) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    // Stage 1 register: capture accepted samples
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_ch_ok <= 1'b0;
            s1_ch    <= '0;
            s1_x     <= '0;
        end else begin
            if (in_ready_o) begin
                s1_valid <= in_valid_i;
            end
            if (accept) begin
                s1_mode  <= mode_i;
                s1_ch_ok <= in_ch_ok;
                s1_ch    <= in_ch_i;
                s1_x     <= x_in_i;
            end
        end
    end

    // Stage 2 register: capture the feedback-corrected value
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid <= 1'b0;
            s2_ch_ok <= 1'b0;
            s2_ch    <= '0;
            s2_v     <= '0;
        end else begin
            if (s2_free) begin
                s2_valid <= s1_valid;
            end
            if (s1_adv) begin
                s2_ch_ok <= s1_ch_ok;
                s2_ch    <= s1_ch;
                s2_v     <= v;
            end
        end
    end

    // Output register: hold the result stable until the consumer takes it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            out_ch_o    <= '0;
            q_out_o     <= '0;
            err_o       <= '0;
            sat_o       <= 1'b0;
        end else begin
            if (out_free) begin
                out_valid_o <= s2_valid;
            end
            if (s2_adv) begin
                out_ch_o <= s2_ch;
                q_out_o  <= q_cl[OUT_W-1:0];
                err_o    <= e_sat;
                sat_o    <= q_sat;
            end
        end
    end

    // Error memory: write the residual as each valid-channel sample leaves stage 2
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: this memory is cleared on reset, so the first feedback term on each channel is zero.
        if (!rst_ni) begin
            for (int i = 0; i < N_CH; i++) begin
                e_mem[i] <= '0;
            end
        end else if (s2_adv && s2_ch_ok) begin
            e_mem[s2_ch] <= e_sat;
        end
    end

`ifdef NS_QUANTIZER_SAT_CNT_EN
    // Saturating count of output transfers flagged as clamped
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sat_cnt_o <= '0;
        end else if (out_valid_o && out_ready_i && sat_o && (sat_cnt_o != 16'hFFFF)) begin
            sat_cnt_o <= sat_cnt_o + 16'd1;
        end
    end
`endif

endmodule
